// File: rtl/icap_stream_gearbox_pkg.sv
// Shared constants and helpers for the ICAP stream gearbox (AES block to ICAP word).
package icap_stream_gearbox_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned ICAP_W      = 32;

    // Number of output slices produced by one input word.
    function automatic int unsigned slice_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Reverse bit order within one byte.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_stream_gearbox_slice_mux.sv
// Combinational slice selector with optional per-byte bit reversal.
// Build option: ICAP_BITSWAP_EN enables the byte bit-reverse on the selected slice.
module gearbox_slice_mux
    import icap_stream_gearbox_pkg::*;
#(
    parameter int unsigned IN_W      = AES_BLOCK_W,
    parameter int unsigned OUT_W     = ICAP_W,
    parameter bit          MSW_FIRST = 1'b1,
    parameter int unsigned SW        = 2
) (
    input  logic [IN_W-1:0]  word,
    input  logic [SW-1:0]    sel,
    output logic [OUT_W-1:0] slice
);

    localparam int unsigned R = slice_ratio(IN_W, OUT_W);

    logic [OUT_W-1:0] plain;

    // Slice index 0 maps to the top of the word when MSW_FIRST is set.
    always_comb begin
        plain = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (sel == SW'(i)) begin
                if (MSW_FIRST) begin
                    plain = word[(R - 1 - i) * OUT_W +: OUT_W];
                end else begin
                    plain = word[i * OUT_W +: OUT_W];
                end
            end
        end
    end

`ifdef ICAP_BITSWAP_EN
    always_comb begin
        slice = plain;
        for (int unsigned b = 0; b < OUT_W / 8; b++) begin
            slice[b * 8 +: 8] = bitrev8(plain[b * 8 +: 8]);
        end
    end
`else
    assign slice = plain;
`endif

endmodule

// File: rtl/icap_stream_gearbox.sv
// Wide-to-narrow stream gearbox feeding an ICAP port: DEPTH-entry word store, serialised OUT_W slices.
// Build option: ICAP_BITSWAP_EN (handled in gearbox_slice_mux).
module icap_stream_gearbox
    import icap_stream_gearbox_pkg::*;
#(
    parameter int unsigned IN_W      = AES_BLOCK_W,
    parameter int unsigned OUT_W     = ICAP_W,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSW_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       write_en,
    input  logic [IN_W-1:0]            data_in,
    output logic                       in_ready,
    input  logic                       read_en,
    output logic [OUT_W-1:0]           data_out,
    output logic                       data_valid,
    output logic                       icap_csib,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int unsigned R  = slice_ratio(IN_W, OUT_W);
    localparam int unsigned SW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [IN_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [SW-1:0]    slice_q;
    logic             full_q;
    logic             overflow_q;
    logic             push;
    logic             consume;
    logic             pop;
    logic [OUT_W-1:0] mux_out;

    // full_q is registered, so a pop while full only frees space from the next cycle.
    assign in_ready   = ~rst & ~flush & ~full_q;
    assign push       = write_en & in_ready;
    assign data_valid = (level_q != '0);
    assign consume    = data_valid & read_en;
    assign pop        = consume & (slice_q == SW'(R - 1));
    assign icap_csib  = ~consume;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign data_out   = data_valid ? mux_out : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            slice_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            slice_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (consume) begin
                slice_q <= pop ? '0 : slice_q + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    level_q <= level_q + 1'b1;
                    full_q  <= (level_q == LW'(DEPTH - 1));
                end
                2'b01: begin
                    level_q <= level_q - 1'b1;
                    full_q  <= 1'b0;
                end
                default: ;
            endcase
            if (write_en & ~in_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    gearbox_slice_mux #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSW_FIRST (MSW_FIRST),
        .SW        (SW)
    ) u_slice_mux (
        .word  (mem[rd_ptr]),
        .sel   (slice_q),
        .slice (mux_out)
    );

endmodule

// File: tb/tb_icap_stream_gearbox.sv
// Self-checking bench for icap_stream_gearbox against a queue-based reference model.
module tb_icap_stream_gearbox;

    localparam int unsigned IN_W  = 128;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned R     = IN_W / OUT_W;
    localparam bit          MSW   = 1'b1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              write_en = 1'b0;
    logic              read_en = 1'b0;
    logic [IN_W-1:0]   data_in = '0;
    logic              in_ready;
    logic              data_valid;
    logic              icap_csib;
    logic              overflow;
    logic [OUT_W-1:0]  data_out;
    logic [2:0]        level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: accepted words in order, slice index within the head word, sticky overflow.
    logic [IN_W-1:0] q[$];
    int unsigned     k = 0;
    bit              ovf = 1'b0;

    always #5 clk = ~clk;

    icap_stream_gearbox #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .DEPTH     (DEPTH),
        .MSW_FIRST (MSW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .write_en   (write_en),
        .data_in    (data_in),
        .in_ready   (in_ready),
        .read_en    (read_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .icap_csib  (icap_csib),
        .level      (level),
        .overflow   (overflow)
    );

    function automatic logic [OUT_W-1:0] exp_slice(input logic [IN_W-1:0] w, input int unsigned idx);
        int unsigned     sh;
        logic [IN_W-1:0] t;
        logic [OUT_W-1:0] s;
        logic [OUT_W-1:0] r;
        sh = MSW ? (R - 1 - idx) * OUT_W : idx * OUT_W;
        t = w >> sh;
        s = t[OUT_W-1:0];
        r = s;
`ifdef ICAP_BITSWAP_EN
        for (int unsigned b = 0; b < OUT_W; b++) begin
            r[(b / 8) * 8 + 7 - (b % 8)] = s[b];
        end
`endif
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs to the model, then advance the model.
    task automatic step(input bit we, input logic [IN_W-1:0] din, input bit re, input bit fl);
        bit valid;
        bit rdy;
        logic [OUT_W-1:0] exp_out;
        @(negedge clk);
        write_en = we;
        data_in  = din;
        read_en  = re;
        flush    = fl;
        #1;
        valid   = (q.size() != 0);
        rdy     = !rst && !fl && (q.size() < DEPTH);
        exp_out = valid ? exp_slice(q[0], k) : '0;
        check("level",      IN_W'(level),      IN_W'(q.size()));
        check("data_valid", IN_W'(data_valid), IN_W'(valid));
        check("data_out",   IN_W'(data_out),   IN_W'(exp_out));
        check("in_ready",   IN_W'(in_ready),   IN_W'(rdy));
        check("icap_csib",  IN_W'(icap_csib),  IN_W'(!(valid && re)));
        check("overflow",   IN_W'(overflow),   IN_W'(ovf));
        if (rst) begin
            q.delete();
            k   = 0;
            ovf = 1'b0;
        end else if (fl) begin
            q.delete();
            k = 0;
        end else begin
            if (valid && re) begin
                k++;
                if (k == R) begin
                    void'(q.pop_front());
                    k = 0;
                end
            end
            if (we && rdy) begin
                q.push_back(din);
            end else if (we) begin
                ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        q.delete();
        k   = 0;
        ovf = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned sent;
        bit          w;
        bit          rd;
        logic [IN_W-1:0] d;

        do_reset();

        // Ordering: one known word, four slices in consecutive cycles.
        step(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

`ifdef ICAP_BITSWAP_EN
        step(1'b1, 128'h01020304_00000000_00000000_00000000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("bitswap", IN_W'(data_out), IN_W'(32'h8040C020));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
`endif

        // Fill with no reads, fifth write overflows and is dropped.
        for (int i = 0; i < 5; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Stall three cycles mid-entry.
        step(1'b1, rnd_word(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush on slice 2 with a concurrent write.
        step(1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b1, rnd_word(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rnd_word(), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Wrap: ten words streamed with read_en held high.
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            w = (sent < 10) && (q.size() < DEPTH);
            step(w, rnd_word(), 1'b1, 1'b0);
            if (w) sent++;
        end

        // Random traffic with occasional flush.
        for (int c = 0; c < 300; c++) begin
            w  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 3) != 0);
            d  = rnd_word();
            step(w, d, rd, ($urandom_range(0, 40) == 0));
        end

        // Reset mid-stream discards partial data and clears overflow.
        step(1'b1, rnd_word(), 1'b1, 1'b0);
        step(1'b1, rnd_word(), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
